// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// EX-stage ALU. It takes a 4-bit ALUControl code and two operands, and returns
// a registered result plus a Zero/branch flag. One operation is accepted per
// Start while Busy is low. Every code finishes in one clock, except mul
// (code 8). By default mul runs a WIDTH-step shift-add sequence, and Busy is
// held high during it.
//
// Build option:
//   ALU_EXEC_FAST_MUL_EN  When defined, mul is a single-cycle full product
//                         truncated to WIDTH bits. The iterative engine is
//                         removed from the build and Busy is tied low.
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset      in   synchronous, active-high
//   Start      in   request, sampled only while Busy=0
//   ALUControl in   [3:0] operation code
//   A, B       in   [WIDTH-1:0] operands
//   Shamt      in   [4:0] shift amount for sll/srl
//   ALUResult  out  [WIDTH-1:0] registered result, held until the next completion
//   Zero       out  registered zero / branch-taken flag
//   Busy       out  multi-cycle operation in flight
//   Done       out  one-cycle pulse when a result becomes valid
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Shamt,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    localparam logic [3:0] OP_MUL = 4'd8;

    // Single-cycle datapath. Codes 10-14 are branch tests: their verdict goes
    // in Zero and the result stays 0.
    logic [WIDTH-1:0] sc_res;
    logic             sc_zero;

    always_comb begin
        sc_res  = '0;
        sc_zero = 1'b0;
        case (ALUControl)
            4'd0:  sc_res = A + B;
            4'd1:  sc_res = A - B;
            4'd2:  sc_res = A & B;
            4'd3:  sc_res = A | B;
            4'd4:  sc_res = ~(A | B);
            4'd5:  sc_res = A ^ B;
            4'd6:  sc_res = B << Shamt;
            4'd7:  sc_res = B >> Shamt;
`ifdef ALU_EXEC_FAST_MUL_EN
            4'd8:  sc_res = A * B;
`else
            4'd8:  sc_res = '0;      // the iterative engine produces this result
`endif
            4'd9:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'd10: sc_zero = ~A[WIDTH-1];
            4'd11: sc_zero = (A != B);
            4'd12: sc_zero = ~A[WIDTH-1] && (A != '0);
            4'd13: sc_zero = A[WIDTH-1] || (A == '0);
            4'd14: sc_zero = A[WIDTH-1];
            default: sc_zero = 1'b1;  // code 15
        endcase
        if (ALUControl <= 4'd9)
            sc_zero = (sc_res == '0);
    end

    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             done_q;

    assign ALUResult = res_q;
    assign Zero      = zero_q;
    assign Done      = done_q;

`ifdef ALU_EXEC_FAST_MUL_EN

    assign Busy = 1'b0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= Start;
            if (Start) begin
                res_q  <= sc_res;
                zero_q <= sc_zero;
            end
        end
    end

`else

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_d;
    logic             zero_d, done_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_step;

    assign Busy = busy_q;

    // This step's partial product is folded in before the test for the
    // final step. Because of that, the last edge can publish the completed
    // sum directly.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (ALUControl == OP_MUL) begin
                        mcand_d  = A;
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = S_MUL;
                    end else begin
                        res_d  = sc_res;
                        zero_d = sc_zero;
                        done_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    res_d   = acc_step;
                    zero_d  = (acc_step == '0);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            res_q    <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed testbench for alu_exec_unit at WIDTH=32. Inputs change on the
// falling edge and outputs are sampled on the falling edge, so every sample
// sits half a cycle away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    localparam int WIDTH = 32;
`ifdef ALU_EXEC_FAST_MUL_EN
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_BUSY = WIDTH;
`endif

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] A, B;
    logic [4:0]       Shamt;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero, Busy, Done;

    int errors = 0;
    int checks = 0;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ALUControl(ALUControl),
        .A(A), .B(B), .Shamt(Shamt), .ALUResult(ALUResult), .Zero(Zero),
        .Busy(Busy), .Done(Done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Drive one request across a single rising edge. On return the sample
    // point lies just after the accepting edge.
    task automatic start_op(input logic [3:0] code, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] sh);
        @(negedge Clk);
        Start = 1'b1; ALUControl = code; A = a; B = b; Shamt = sh;
        @(negedge Clk);
        Start = 1'b0; A = 32'hDEAD_BEEF; B = 32'hCAFE_F00D; ALUControl = 4'd15;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; ALUControl = 4'd0; A = '0; B = '0; Shamt = '0;
        repeat (3) @(negedge Clk);
        checks++; if (ALUResult !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", ALUResult); end
        checks++; if (Zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=0", Zero); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", Done); end
        Reset = 1'b0;
    endtask

    task automatic test_single_cycle();
        logic [3:0]  code [20];
        logic [31:0] va   [20];
        logic [31:0] vb   [20];
        logic [4:0]  vs   [20];
        logic [31:0] er   [20];
        logic        ez   [20];
        int n = 0;
        code[n]=0;  va[n]=5;            vb[n]=7;            vs[n]=0;  er[n]=12;           ez[n]=0; n++;
        code[n]=1;  va[n]=32'h1234;     vb[n]=32'h1234;     vs[n]=0;  er[n]=0;            ez[n]=1; n++;
        code[n]=2;  va[n]=32'hF0F0FF00; vb[n]=32'h0FF0F0F0; vs[n]=0;  er[n]=32'h00F0F000; ez[n]=0; n++;
        code[n]=3;  va[n]=32'hF0F0FF00; vb[n]=32'h0FF0F0F0; vs[n]=0;  er[n]=32'hFFF0FFF0; ez[n]=0; n++;
        code[n]=4;  va[n]=32'hFFFF0000; vb[n]=32'h0000FF00; vs[n]=0;  er[n]=32'h000000FF; ez[n]=0; n++;
        code[n]=5;  va[n]=32'hAAAA5555; vb[n]=32'hFFFF0000; vs[n]=0;  er[n]=32'h55555555; ez[n]=0; n++;
        code[n]=6;  va[n]=0;            vb[n]=1;            vs[n]=31; er[n]=32'h80000000; ez[n]=0; n++;
        code[n]=7;  va[n]=0;            vb[n]=32'h80000000; vs[n]=31; er[n]=1;            ez[n]=0; n++;
        code[n]=9;  va[n]=32'hFFFFFFFF; vb[n]=1;            vs[n]=0;  er[n]=1;            ez[n]=0; n++;
        code[n]=9;  va[n]=1;            vb[n]=32'hFFFFFFFF; vs[n]=0;  er[n]=0;            ez[n]=1; n++;
        code[n]=10; va[n]=0;            vb[n]=0;            vs[n]=0;  er[n]=0;            ez[n]=1; n++;
        code[n]=10; va[n]=32'h80000000; vb[n]=0;            vs[n]=0;  er[n]=0;            ez[n]=0; n++;
        code[n]=11; va[n]=1;            vb[n]=2;            vs[n]=0;  er[n]=0;            ez[n]=1; n++;
        code[n]=11; va[n]=7;            vb[n]=7;            vs[n]=0;  er[n]=0;            ez[n]=0; n++;
        code[n]=12; va[n]=0;            vb[n]=0;            vs[n]=0;  er[n]=0;            ez[n]=0; n++;
        code[n]=12; va[n]=1;            vb[n]=0;            vs[n]=0;  er[n]=0;            ez[n]=1; n++;
        code[n]=13; va[n]=0;            vb[n]=0;            vs[n]=0;  er[n]=0;            ez[n]=1; n++;
        code[n]=14; va[n]=32'h80000000; vb[n]=0;            vs[n]=0;  er[n]=0;            ez[n]=1; n++;
        code[n]=15; va[n]=5;            vb[n]=5;            vs[n]=0;  er[n]=0;            ez[n]=1; n++;
        code[n]=0;  va[n]=32'hFFFFFFFF; vb[n]=1;            vs[n]=0;  er[n]=0;            ez[n]=1; n++;
        for (int i = 0; i < n; i++) begin
            start_op(code[i], va[i], vb[i], vs[i]);
            checks++; if (ALUResult !== er[i]) begin errors++; $display("FAIL op%0d_code%0d_result got=%h exp=%h", i, code[i], ALUResult, er[i]); end
            checks++; if (Zero !== ez[i]) begin errors++; $display("FAIL op%0d_code%0d_zero got=%b exp=%b", i, code[i], Zero, ez[i]); end
            checks++; if (Done !== 1'b1) begin errors++; $display("FAIL op%0d_done_high got=%b exp=1", i, Done); end
            checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL op%0d_busy got=%b exp=0", i, Busy); end
            @(negedge Clk);
            checks++; if (Done !== 1'b0) begin errors++; $display("FAIL op%0d_done_pulse got=%b exp=0", i, Done); end
            checks++; if (ALUResult !== er[i]) begin errors++; $display("FAIL op%0d_hold got=%h exp=%h", i, ALUResult, er[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  code [4] = '{4'd0, 4'd1, 4'd5, 4'd6};
        logic [31:0] va   [4] = '{32'd1, 32'd10, 32'hFF, 32'd0};
        logic [31:0] vb   [4] = '{32'd1, 32'd3, 32'h0F, 32'd3};
        logic [31:0] er   [4] = '{32'd2, 32'd7, 32'hF0, 32'd48};
        @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            Start = 1'b1; ALUControl = code[i]; A = va[i]; B = vb[i]; Shamt = 5'd4;
            @(negedge Clk);
            checks++; if (ALUResult !== er[i]) begin errors++; $display("FAIL b2b%0d_result got=%h exp=%h", i, ALUResult, er[i]); end
            checks++; if (Done !== 1'b1) begin errors++; $display("FAIL b2b%0d_done got=%b exp=1", i, Done); end
        end
        Start = 1'b0;
        @(negedge Clk);
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL b2b_done_fall got=%b exp=0", Done); end
    endtask

    // Runs one mul and counts the sampled cycles with Busy high. A stray
    // add request is injected partway through; it must be ignored.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_r, input logic exp_z);
        int busy_cnt = 0;
        int cyc = 0;
        logic overlap = 1'b0;
        start_op(4'd8, a, b, 5'd0);
        while (Busy === 1'b1 && cyc < 100) begin
            if (Done === 1'b1) overlap = 1'b1;
            busy_cnt++;
            cyc++;
            Start = (cyc == 5); ALUControl = 4'd0; A = 32'd1; B = 32'd1;
            @(negedge Clk);
        end
        Start = 1'b0;
        checks++; if (busy_cnt !== MUL_BUSY) begin errors++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", tag, busy_cnt, MUL_BUSY); end
        checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL %s_done_while_busy got=%b exp=0", tag, overlap); end
        checks++; if (Done !== 1'b1) begin errors++; $display("FAIL %s_done got=%b exp=1", tag, Done); end
        checks++; if (ALUResult !== exp_r) begin errors++; $display("FAIL %s_result got=%h exp=%h", tag, ALUResult, exp_r); end
        checks++; if (Zero !== exp_z) begin errors++; $display("FAIL %s_zero got=%b exp=%b", tag, Zero, exp_z); end
        @(negedge Clk);
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got=%b exp=0", tag, Done); end
        checks++; if (ALUResult !== exp_r) begin errors++; $display("FAIL %s_hold got=%h exp=%h", tag, ALUResult, exp_r); end
    endtask

    task automatic test_mul();
        run_mul("mul_ffff_x3", 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 1'b0);
        run_mul("mul_wrap0", 32'h00010000, 32'h00010000, 32'h0, 1'b1);
        run_mul("mul_small", 32'd1234, 32'd5678, 32'd7006652, 1'b0);
        // A single-cycle request accepted in the same cycle Done is high
        start_op(4'd8, 32'd6, 32'd7, 5'd0);
        repeat (MUL_BUSY) @(negedge Clk);
        Start = 1'b1; ALUControl = 4'd0; A = 32'd100; B = 32'd23;
        checks++; if (ALUResult !== 32'd42) begin errors++; $display("FAIL mul_then_add_mulres got=%0d exp=42", ALUResult); end
        @(negedge Clk);
        Start = 1'b0;
        checks++; if (ALUResult !== 32'd123 || Done !== 1'b1) begin errors++; $display("FAIL mul_then_add got=%0d/%b exp=123/1", ALUResult, Done); end
    endtask

    task automatic test_reset_mid_mul();
        logic seen = 1'b0;
        start_op(4'd0, 32'd3, 32'd5, 5'd0);       // leave a nonzero result behind
        start_op(4'd8, 32'd3, 32'd5, 5'd0);
        repeat (9) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_mul_busy got=%b exp=0", Busy); end
        checks++; if (ALUResult !== 32'h0) begin errors++; $display("FAIL rst_mul_result got=%h exp=0", ALUResult); end
        checks++; if (Zero !== 1'b0) begin errors++; $display("FAIL rst_mul_zero got=%b exp=0", Zero); end
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1) seen = 1'b1;
            @(negedge Clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mul_no_done got=%b exp=0", seen); end
        // Reset and Start together: reset wins
        @(negedge Clk);
        Reset = 1'b1; Start = 1'b1; ALUControl = 4'd0; A = 32'd9; B = 32'd9;
        @(negedge Clk);
        Reset = 1'b0; Start = 1'b0;
        checks++; if (Done !== 1'b0 || ALUResult !== 32'h0) begin errors++; $display("FAIL rst_vs_start got=%b/%h exp=0/0", Done, ALUResult); end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_back_to_back();
        test_mul();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
